// File: rtl/tile_sram_pkg.sv
// Shared types for the tile SRAM arbiter: FSM states and response owner tags.
package tile_sram_pkg;

   typedef enum logic {
      LD_PRIO   = 1'b0,
      CPU_FORCE = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_LD   = 2'd2
   } owner_e;

endpackage

// File: rtl/tile_sram_rsp_pipe.sv
// Two-stage read response path: stage 1 holds the owner of the read issued
// last cycle while the SRAM produces data; stage 2 captures that data into the
// owner's response port and pulses its valid.
module tile_sram_rsp_pipe
   import tile_sram_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  owner_e            rd_owner,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata
);

   owner_e tag_q;

   // Stage 1: remember who issued the read the SRAM is serving now.
   always_ff @(posedge clk) begin
      if (rst) tag_q <= OWN_NONE;
      else     tag_q <= rd_owner;
   end

   // Stage 2: route SRAM data to its owner; rdata holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid <= 1'b0;
         ld_rvalid  <= 1'b0;
         cpu_rdata  <= '0;
         ld_rdata   <= '0;
      end else begin
         cpu_rvalid <= (tag_q == OWN_CPU);
         ld_rvalid  <= (tag_q == OWN_LD);
         if (tag_q == OWN_CPU) cpu_rdata <= sram_rdata;
         if (tag_q == OWN_LD)  ld_rdata  <= sram_rdata;
      end
   end

endmodule

// File: rtl/tile_sram_arbiter.sv
// Single-port tile SRAM arbiter between the CPU load port and the tile loader.
// Loader normally wins; after MAX_WAIT contended losses the CPU is forced in.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   LD_PRIO   | loader wins when requesting; CPU losses counted in wait_cnt
//   CPU_FORCE | CPU granted unconditionally this cycle, loader stalled
module tile_sram_arbiter
   import tile_sram_pkg::*;
#(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 32,
   parameter int BYTE_W   = DATA_W / 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [BYTE_W-1:0] cpu_wmask,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic [BYTE_W-1:0] sram_wmask,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("tile_sram_arbiter: MAX_WAIT must be >= 1");
   end

   arb_state_e       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic [CNT_W-1:0] wait_inc;
   logic             cpu_wr;
   owner_e           rd_owner;

   assign wait_inc = wait_cnt + CNT_W'(1);

   // State and starvation counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LD_PRIO;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Grant decision from requests and state only; grants held low in reset.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      cpu_gnt      = 1'b0;
      ld_gnt       = 1'b0;
      if (!rst) begin
         case (state)
            LD_PRIO: begin
               if (ld_req) begin
                  ld_gnt = 1'b1;
                  if (cpu_req) begin
                     wait_cnt_nxt = wait_inc;
                     if (wait_inc == MAX_CNT) state_nxt = CPU_FORCE;
                  end else begin
                     wait_cnt_nxt = '0;
                  end
               end else begin
                  cpu_gnt      = cpu_req;
                  wait_cnt_nxt = '0;
               end
            end
            CPU_FORCE: begin
               // A dropped cpu_req here is illegal; fall back without granting.
               cpu_gnt      = cpu_req;
               wait_cnt_nxt = '0;
               state_nxt    = LD_PRIO;
            end
            default: begin
               state_nxt    = LD_PRIO;
               wait_cnt_nxt = '0;
            end
         endcase
      end
   end

   // SRAM port mux from the winner; write payload zeroed unless a CPU write.
   always_comb begin
      cpu_wr     = cpu_gnt & cpu_we;
      sram_en    = cpu_gnt | ld_gnt;
      sram_we    = cpu_wr;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wmask = '0;
      rd_owner   = OWN_NONE;
      if (cpu_gnt) begin
         sram_addr = cpu_addr;
         if (cpu_wr) begin
            sram_wdata = cpu_wdata;
            sram_wmask = cpu_wmask;
         end else begin
            rd_owner = OWN_CPU;
         end
      end else if (ld_gnt) begin
         sram_addr = ld_addr;
         rd_owner  = OWN_LD;
      end
   end

   tile_sram_rsp_pipe #(
      .DATA_W (DATA_W)
   ) u_rsp_pipe (
      .clk        (clk),
      .rst        (rst),
      .rd_owner   (rd_owner),
      .sram_rdata (sram_rdata),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ld_rvalid  (ld_rvalid),
      .ld_rdata   (ld_rdata)
   );

endmodule

// File: tb/tb_tile_sram_arbiter.sv
// Bench for tile_sram_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model (winner rule, shadow memory,
// response queue with due cycles).
module tb_tile_sram_arbiter;
   import tile_sram_pkg::*;

   localparam int ADDR_W   = 13;
   localparam int DATA_W   = 32;
   localparam int BYTE_W   = 4;
   localparam int MAX_WAIT = 4;
   localparam int NOBS     = 8192;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [BYTE_W-1:0] cpu_wmask;
   logic              cpu_gnt, cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_gnt, ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;
   logic              sram_en, sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [BYTE_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_rdata;

   tile_sram_arbiter #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .BYTE_W (BYTE_W), .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk (clk), .rst (rst),
      .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
      .cpu_wdata (cpu_wdata), .cpu_wmask (cpu_wmask), .cpu_gnt (cpu_gnt),
      .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
      .ld_req (ld_req), .ld_addr (ld_addr), .ld_gnt (ld_gnt),
      .ld_rvalid (ld_rvalid), .ld_rdata (ld_rdata),
      .sram_en (sram_en), .sram_we (sram_we), .sram_addr (sram_addr),
      .sram_wdata (sram_wdata), .sram_wmask (sram_wmask), .sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   // SRAM behavioural model: byte-masked write, 1-cycle read latency.
   logic [DATA_W-1:0] mem [1 << ADDR_W];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) begin
            for (int b = 0; b < BYTE_W; b++)
               if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int                owner;   // 1 = CPU, 2 = loader
      logic [DATA_W-1:0] data;
      int                due;
   } rsp_t;

   rsp_t              rq[$];
   logic [DATA_W-1:0] shadow [1 << ADDR_W];
   int                lost = 0;
   logic [DATA_W-1:0] last_c = '0, last_l = '0;
   logic              rst_prev = 1'b0;
   logic              m_cpu_won, m_ld_won;

   logic [1:0]        obs_gnt [NOBS];
   logic              obs_crv [NOBS];
   logic              obs_lrv [NOBS];
   logic [DATA_W-1:0] obs_crd [NOBS];
   logic [DATA_W-1:0] obs_lrd [NOBS];

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] nw,
                                               input logic [BYTE_W-1:0] m);
      logic [DATA_W-1:0] r;
      r = old;
      for (int b = 0; b < BYTE_W; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic model_step();
      rsp_t r;
      logic ecv, elv;
      logic [ADDR_W-1:0] ea;
      if (cyc < NOBS) begin
         obs_gnt[cyc] = {cpu_gnt, ld_gnt};
         obs_crv[cyc] = cpu_rvalid; obs_crd[cyc] = cpu_rdata;
         obs_lrv[cyc] = ld_rvalid;  obs_lrd[cyc] = ld_rdata;
      end
      m_cpu_won = 1'b0;
      m_ld_won  = 1'b0;
      if (rst) begin
         chk("rst_cpu_gnt", cpu_gnt, 0);
         chk("rst_ld_gnt", ld_gnt, 0);
         chk("rst_sram_en", sram_en, 0);
         chk("rst_sram_we", sram_we, 0);
         chk("rst_sram_addr", sram_addr, 0);
         chk("rst_sram_wdata", sram_wdata, 0);
         chk("rst_sram_wmask", sram_wmask, 0);
         if (rst_prev) begin
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_ld_rvalid", ld_rvalid, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_ld_rdata", ld_rdata, 0);
            chk("rst_state", dut.state, LD_PRIO);
            chk("rst_wait_cnt", dut.wait_cnt, 0);
         end
         rq.delete();
         lost = 0;
         last_c = '0;
         last_l = '0;
         return;
      end
      ecv = 1'b0;
      elv = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         if (r.owner == 1) begin ecv = 1'b1; last_c = r.data; end
         else              begin elv = 1'b1; last_l = r.data; end
      end
      chk("cpu_rvalid", cpu_rvalid, ecv);
      chk("cpu_rdata", cpu_rdata, last_c);
      chk("ld_rvalid", ld_rvalid, elv);
      chk("ld_rdata", ld_rdata, last_l);
      chk("both_rvalid", cpu_rvalid & ld_rvalid, 0);

      // Winner rule: CPU forced after MAX_WAIT consecutive contended losses.
      if (cpu_req && lost == MAX_WAIT) begin
         m_cpu_won = 1'b1; lost = 0;
      end else if (ld_req) begin
         m_ld_won = 1'b1; lost = cpu_req ? lost + 1 : 0;
      end else if (cpu_req) begin
         m_cpu_won = 1'b1; lost = 0;
      end else begin
         lost = 0;
      end

      ea = m_cpu_won ? cpu_addr : (m_ld_won ? ld_addr : '0);
      chk("cpu_gnt", cpu_gnt, m_cpu_won);
      chk("ld_gnt", ld_gnt, m_ld_won);
      chk("sram_en", sram_en, m_cpu_won | m_ld_won);
      chk("sram_we", sram_we, m_cpu_won & cpu_we);
      chk("sram_addr", sram_addr, ea);
      chk("sram_wdata", sram_wdata, (m_cpu_won && cpu_we) ? cpu_wdata : '0);
      chk("sram_wmask", sram_wmask, (m_cpu_won && cpu_we) ? cpu_wmask : '0);

      if (m_cpu_won && cpu_we) begin
         shadow[cpu_addr] = merge(shadow[cpu_addr], cpu_wdata, cpu_wmask);
      end else if (m_cpu_won) begin
         r.owner = 1; r.data = shadow[cpu_addr]; r.due = cyc + 2;
         rq.push_back(r);
      end else if (m_ld_won) begin
         r.owner = 2; r.data = shadow[ld_addr]; r.due = cyc + 2;
         rq.push_back(r);
      end
   endtask

   // One clock cycle: inputs already applied, check mid-cycle, advance.
   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      rst_prev = rst;
      #1;
      cyc++;
   endtask

   task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [BYTE_W-1:0] m);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
      tick();
      cpu_req = 1'b0;
   endtask

   int t0;

   initial begin
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
      ld_req = 1'b0; ld_addr = '0;
      for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = '0;
      repeat (3) tick();
      rst = 1'b0;

      // Idle: nothing on the SRAM port, no responses.
      repeat (10) tick();

      // Preload a working set through the CPU port.
      for (int i = 0; i < 16; i++) cpu_access(1'b1, ADDR_W'(i), $urandom, 4'hF);
      for (int i = 0; i < 8; i++)  cpu_access(1'b1, ADDR_W'(i), 32'h100 + i, 4'hF);

      // Loader only: 8 back-to-back reads.
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         ld_req = 1'b1; ld_addr = ADDR_W'(i);
         tick();
      end
      ld_req = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 8; i++) begin
         chk("ld_only_rvalid", obs_lrv[t0 + 2 + i], 1);
         chk("ld_only_rdata", obs_lrd[t0 + 2 + i], 32'h100 + i);
      end

      // CPU only: masked write then read of the same word next cycle.
      cpu_access(1'b1, 13'd5, 32'h11223344, 4'hF);
      cpu_access(1'b1, 13'd5, 32'hDEADBEEF, 4'b0011);
      t0 = cyc;
      cpu_access(1'b0, 13'd5, '0, '0);
      repeat (3) tick();
      chk("cpu_rmw_rvalid", obs_crv[t0 + 2], 1);
      chk("cpu_rmw_rdata", obs_crd[t0 + 2], 32'h1122BEEF);
      chk("cpu_rmw_early", obs_crv[t0 + 1], 0);

      // Contention: both held, CPU forced in on the fifth cycle.
      t0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd3;
      ld_req  = 1'b1; ld_addr = 13'd4;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (m_cpu_won) cpu_req = 1'b0;
      end
      ld_req = 1'b0;
      for (int k = 0; k < 6; k++)
         chk("contend_gnt", obs_gnt[t0 + k], (k == 4) ? 2'b10 : 2'b01);
      chk("contend_wait_cnt", dut.wait_cnt, 0);
      repeat (3) tick();

      // Interleaved CPU/loader reads to addresses 1 and 2.
      t0 = cyc;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd1; end
         else            begin ld_req = 1'b1; ld_addr = 13'd2; end
         tick();
         cpu_req = 1'b0; ld_req = 1'b0;
      end
      repeat (3) tick();
      for (int k = 0; k < 8; k++) begin
         chk("ilv_cpu_rvalid", obs_crv[t0 + 2 + k], (k % 2 == 0));
         chk("ilv_ld_rvalid", obs_lrv[t0 + 2 + k], (k % 2 == 1));
         if (k % 2 == 0) chk("ilv_cpu_rdata", obs_crd[t0 + 2 + k], 32'h101);
         else            chk("ilv_ld_rdata", obs_lrd[t0 + 2 + k], 32'h102);
      end

      // Reset one cycle after a loader read grant: response discarded.
      t0 = cyc;
      ld_req = 1'b1; ld_addr = 13'd3;
      tick();
      ld_req = 1'b0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      for (int k = 2; k < 8; k++) chk("rst_mid_ld_rvalid", obs_lrv[t0 + k], 0);

      // Random traffic with held requests, heavy loader load.
      cpu_req = 1'b0; ld_req = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = ADDR_W'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            cpu_wmask = BYTE_W'($urandom_range(0, 15));
         end
         if (!ld_req && $urandom_range(0, 3) != 0) begin
            ld_req  = 1'b1;
            ld_addr = ADDR_W'($urandom_range(0, 15));
         end
         tick();
         if (m_cpu_won) cpu_req = 1'b0;
         if (m_ld_won)  ld_req  = 1'b0;
      end
      cpu_req = 1'b0; ld_req = 1'b0;
      repeat (4) tick();
      chk("rsp_drain", rq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tile_sram_arbiter.md
# tile_sram_arbiter

Single-port SRAM arbiter that shares one tile SRAM (W or X) between the CPU load port and the tile loader's read port. It accepts one request per cycle, drives the SRAM's single port, and routes each 1-cycle-latency read response back to its owner. The block replaces the ad-hoc "CPU write wins, loader read dropped" behaviour in the tile system: no request is ever lost, the loader normally has priority, and a starvation counter guarantees the CPU progress.

## Interface
Parameters:
- ADDR_W, 13, flat SRAM word address width (row/k or k/n concatenated by the caller)
- DATA_W, 32, word width
- BYTE_W, DATA_W/8, byte-mask width
- MAX_WAIT, 4, contended cycles the CPU loses before it is forced a grant; must be ≥1 (elaboration assertion)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU request pending; held with payload until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  write data
- cpu_wmask  in  BYTE_W  byte enables
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DATA_W  CPU read data
- ld_req  in  1  loader read request; held with ld_addr until ld_gnt
- ld_addr  in  ADDR_W  loader address
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_rvalid  out  1  loader read data valid (registered)
- ld_rdata  out  DATA_W  loader read data
- sram_en  out  1  SRAM access this cycle
- sram_we  out  1  SRAM write
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_wmask  out  BYTE_W  SRAM byte mask
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after sram_en && !sram_we

## Operation
- FSM states LD_PRIO (reset) and CPU_FORCE.
- LD_PRIO: ld_req wins if asserted; else cpu_req wins. If both asserted, loader granted and wait_cnt increments; when the increment reaches MAX_WAIT, next state CPU_FORCE.
- CPU_FORCE: cpu_req granted unconditionally (loader stalls); wait_cnt ← 0; return to LD_PRIO. If cpu_req dropped (illegal), return to LD_PRIO without grant.
- wait_cnt resets to 0 whenever the CPU is granted or cpu_req is low; width $clog2(MAX_WAIT+1), never wraps.
- At most one of cpu_gnt/ld_gnt per cycle; sram_en = cpu_gnt | ld_gnt; sram_we = cpu_gnt & cpu_we; address/wdata/wmask muxed from the winner; wdata/wmask = 0 when not a CPU write.
- Grants depend only on req inputs and FSM state, never on gnt outputs (no combinational loop).
- Response path: read grant registers owner tag (NONE/CPU/LD) into stage 1; SRAM returns data; stage 2 registers sram_rdata into the owner's rdata and pulses its rvalid. rdata holds last value when rvalid low.
- Writes produce no response.

## Timing
- Grant: same cycle as req when won.
- Read latency: grant at cycle T → rvalid/rdata at T+2. Back-to-back reads fully pipelined, one response per cycle, in grant order.
- CPU write followed next cycle by a read of same address returns the new data (SRAM-ordered).
- Worst-case CPU wait under continuous loader traffic: MAX_WAIT cycles, granted in cycle MAX_WAIT+1.
- Reset values: cpu_gnt, ld_gnt, sram_en, sram_we, cpu_rvalid, ld_rvalid = 0; cpu_rdata, ld_rdata, sram_addr, sram_wdata, sram_wmask = 0; state LD_PRIO; wait_cnt 0; tags NONE.
- Reset mid-operation: in-flight reads discarded, no rvalid after rst deasserts until a new grant.

## Structure
- Package tile_sram_pkg: arb_state_e {LD_PRIO, CPU_FORCE}, owner_e {OWN_NONE, OWN_CPU, OWN_LD}.
- Sub-module tile_sram_rsp_pipe: 2-stage owner tag + data register, demuxes into cpu/ld response ports.
- Top holds FSM, wait counter, request mux.

## Test plan
- Loader only: ld_req reads addr 0..7 back-to-back, SRAM preloaded with addr+0x100 → ld_rvalid for 8 consecutive cycles starting T+2, data 0x100..0x107.
- CPU only: write 0xDEADBEEF mask 4'b0011 to addr 5 (prior 0x11223344), then read → cpu_rdata 0x1122BEEF at T+2.
- Contention, MAX_WAIT=4: ld_req and cpu_req held high → ld_gnt cycles 0–3, cpu_gnt cycle 4, ld_gnt resumes cycle 5; wait_cnt back to 0.
- Interleaved reads: alternate CPU/loader grants to addrs 1/2 → responses routed to correct port in grant order, never both rvalid same cycle.
- Reset mid-read: rst asserted at T+1 after a loader read grant → ld_rvalid stays 0, all outputs at reset values, state LD_PRIO.
- Idle: no requests → sram_en 0 every cycle, no rvalid.
